// File: rtl/cam_match_pipe_if.sv
// Handshake and result bundle for the pipelined CAM match finder.
// master = requester / result consumer, slave = the CAM itself.
interface cam_match_pipe_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned POS_WIDTH  = 16
);
  logic                  flush;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] ins_data;
  logic [POS_WIDTH-1:0]  ins_pos;
  logic                  srch_valid;
  logic                  srch_ready;
  logic [DATA_WIDTH-1:0] srch_data;
  logic [DATA_WIDTH-1:0] srch_mask;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_hit;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [POS_WIDTH-1:0]  res_pos;
  logic                  res_multi;
  logic [ADDR_WIDTH:0]   occupancy;

  modport master (
    output flush, ins_valid, ins_data, ins_pos, srch_valid, srch_data, srch_mask, res_ready,
    input  ins_ready, srch_ready, res_valid, res_hit, res_addr, res_pos, res_multi, occupancy
  );

  modport slave (
    input  flush, ins_valid, ins_data, ins_pos, srch_valid, srch_data, srch_mask, res_ready,
    output ins_ready, srch_ready, res_valid, res_hit, res_addr, res_pos, res_multi, occupancy
  );
endinterface

// File: rtl/cam_match_pipe.sv
// Pipelined masked CAM: round-robin insert, two-stage search (match vector, then
// newest-first priority encode) with valid/ready handshakes on search and result.
module cam_match_pipe #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned POS_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cam_match_pipe_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] key_q [DEPTH];
  logic [POS_WIDTH-1:0]  pos_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DEPTH-1:0]      s1_vec_q, s1_vec_d;

  logic                  res_valid_q, res_valid_d;
  logic                  res_hit_q, res_hit_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic [POS_WIDTH-1:0]  res_pos_q, res_pos_d;
  logic                  res_multi_q, res_multi_d;

  logic                  out_en, srch_rdy, ins_acc, srch_acc, s1_adv;
  logic [DEPTH-1:0]      match_now;
  logic                  enc_found, enc_multi;
  logic [ADDR_WIDTH-1:0] enc_addr, enc_idx;

  assign out_en   = !res_valid_q || bus.res_ready;
  assign srch_rdy = !s1_valid_q || out_en;
  assign ins_acc  = bus.ins_valid && !bus.flush;
  assign srch_acc = bus.srch_valid && srch_rdy;
  assign s1_adv   = s1_valid_q && out_en;

  always_comb begin
    match_now = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_now[i] = valid_q[i] && (((key_q[i] ^ bus.srch_data) & bus.srch_mask) == '0);
    end
  end

  // Scan from wr_ptr-1 (newest) downward so the first hit is the newest match.
  always_comb begin
    enc_found = 1'b0;
    enc_addr  = '0;
    enc_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      enc_idx = wr_ptr_q - ADDR_WIDTH'(k) - ADDR_WIDTH'(1);
      if (!enc_found && s1_vec_q[enc_idx]) begin
        enc_found = 1'b1;
        enc_addr  = enc_idx;
      end
    end
    enc_multi = |(s1_vec_q & (s1_vec_q - DEPTH'(1)));
  end

  always_comb begin
    valid_d     = valid_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    s1_valid_d  = s1_valid_q;
    s1_vec_d    = s1_vec_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_addr_d  = res_addr_q;
    res_pos_d   = res_pos_q;
    res_multi_d = res_multi_q;

    if (bus.flush) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else if (ins_acc) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + ADDR_WIDTH'(1);
      if (occ_q != (ADDR_WIDTH + 1)'(DEPTH)) occ_d = occ_q + (ADDR_WIDTH + 1)'(1);
    end

    if (srch_acc) begin
      s1_valid_d = 1'b1;
      s1_vec_d   = match_now;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    // A slot overwritten (or flushed) under a pending search must never be reported.
    if (bus.flush) s1_vec_d = '0;
    else if (ins_acc) s1_vec_d[wr_ptr_q] = 1'b0;

    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_hit_d   = enc_found;
      res_addr_d  = enc_addr;
      res_pos_d   = enc_found ? pos_q[enc_addr] : '0;
      res_multi_d = enc_multi;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_addr_q  <= '0;
      res_pos_q   <= '0;
      res_multi_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      s1_valid_q  <= s1_valid_d;
      s1_vec_q    <= s1_vec_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_addr_q  <= res_addr_d;
      res_pos_q   <= res_pos_d;
      res_multi_q <= res_multi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_acc) begin
      key_q[wr_ptr_q] <= bus.ins_data;
      pos_q[wr_ptr_q] <= bus.ins_pos;
    end
  end

  assign bus.ins_ready  = !bus.flush;
  assign bus.srch_ready = srch_rdy;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.res_addr   = res_addr_q;
  assign bus.res_pos    = res_pos_q;
  assign bus.res_multi  = res_multi_q;
  assign bus.occupancy  = occ_q;
endmodule
